control_sequencer: RTL and testbench
====================================

# control_sequencer

Microcoded control sequencer for the 4-bit-address accumulator CPU. It issues the per-cycle control strobes that the program counter, MAR, RAM, IR, A/B registers, ALU and output register obey, including the PC's load, drive and increment strobes. It runs a fixed fetch phase (T1–T3) and an opcode-dependent execute phase (T4–T6), handles halt, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 8, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  start/continue enable, sampled in IDLE only
- ir_opcode  in  4  IR[7:4], stable from T4 through T6
- zero_flag  in  1  accumulator-zero flag, sampled in T4
- pc_in  out  1  load PC from bus
- pc_out  out  1  PC drives bus
- pc_inc  out  1  increment PC
- mar_in  out  1  load MAR from bus
- ram_out  out  1  RAM drives bus
- ir_in  out  1  load IR from bus
- ir_out  out  1  IR[3:0] drives bus
- a_in, a_out  out  1 each  accumulator load / drive
- b_in  out  1  B register load
- alu_out  out  1  ALU drives bus
- alu_sub  out  1  ALU subtract select (0 = add)
- out_in  out  1  output register load
- halted  out  1  high in HALT state
- instr_count  out  CNT_W  retired instructions, wraps

## Operation
- States: IDLE, T1, T2, T3, T4, T5, T6, HALT.
- Transitions:
  - IDLE→T1 when run=1, else stay in IDLE.
  - T1→T2→T3→T4→T5→T6 unconditionally.
  - T6→T1 if run=1, else T6→IDLE.
  - T4→HALT if ir_opcode=HLT.
  - HALT is absorbing until reset.
- Strobes are a combinational decode of the registered state and ir_opcode. All strobes are 0 in IDLE, in HALT, and in any T-state not listed below.
- Fetch:
  - T1: pc_out, mar_in.
  - T2: pc_inc.
  - T3: ram_out, ir_in.
- Execute, by opcode:
  - 0x0 LDA: T4 ir_out+mar_in; T5 ram_out+a_in.
  - 0x1 ADD: T4 ir_out+mar_in; T5 ram_out+b_in; T6 alu_out+a_in.
  - 0x2 SUB: as ADD, with alu_sub=1 during T6 only.
  - 0x3 JMP: T4 ir_out+pc_in.
  - 0x4 JZ: T4 ir_out+pc_in if zero_flag=1, else nothing.
  - 0xE OUT: T4 a_out+out_in.
  - 0xF HLT: no strobes; next state HALT.
  - All other opcodes: NOP, full six cycles with execute strobes 0.
- At most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) is active in any cycle. This is guaranteed by the decode.
- instr_count increments by 1 on the T6 exit edge, whether the next state is T1 or IDLE. HLT does not increment it. Wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (async assert, sync-to-clk deassert is the system's responsibility):
  - state=IDLE, instr_count=0, halted=0, all strobes 0, effective immediately.
- Each instruction takes 6 cycles, T1 to T6 inclusive. HLT takes 4 cycles to reach HALT; halted rises in the cycle after T4.
- Strobe for state Tk is valid for the whole cycle Tk. The targeted register captures on the rising edge that ends Tk.
- run falling mid-instruction does not abort. The current instruction completes, then the sequencer goes to IDLE.
- Reset asserted during any T-state or HALT returns to IDLE in the same cycle, with no partial strobes afterwards.
- Start latency: run=1 sampled in IDLE on edge n puts T1 (pc_out) in cycle n+1.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_JZ, OP_OUT, OP_HLT);
  - state enum encoding;
  - control-word bit-index constants, for reuse by datapath and bench.
- One sub-module, tstate_ring: the state register plus the next-state logic and the halt latch.
- The top module holds the strobe decode and instr_count.

## Test plan
- Reset with run=0 → all strobes 0, halted=0, instr_count=0; stays IDLE for 10 cycles.
- run=1, ir_opcode=0x0 → T1 pc_out+mar_in, T2 pc_inc, T3 ram_out+ir_in, T4 ir_out+mar_in, T5 ram_out+a_in, T6 none; instr_count=1.
- ir_opcode=0x2 → alu_sub=1 only in T6, together with alu_out+a_in. ir_opcode=0x1 → alu_sub=0 throughout.
- ir_opcode=0x4, zero_flag=1 → pc_in+ir_out in T4. Same with zero_flag=0 → no strobes in T4–T6.
- ir_opcode=0xF → halted=1 from cycle 5 onward, all strobes 0 for 20 cycles, instr_count unchanged. rst_n low → IDLE and halted=0 without a clock edge.
- CNT_W=8, run held high for 256 NOP instructions → instr_count reaches 255 then wraps to 0. run dropped in T3 → completes T6, then IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer states and
// control-word bit positions used by the sequencer, datapath and bench.
package cpu_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_JZ  = 4'h4;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } state_e;

    localparam int CW_PC_IN   = 0;
    localparam int CW_PC_OUT  = 1;
    localparam int CW_PC_INC  = 2;
    localparam int CW_MAR_IN  = 3;
    localparam int CW_RAM_OUT = 4;
    localparam int CW_IR_IN   = 5;
    localparam int CW_IR_OUT  = 6;
    localparam int CW_A_IN    = 7;
    localparam int CW_A_OUT   = 8;
    localparam int CW_B_IN    = 9;
    localparam int CW_ALU_OUT = 10;
    localparam int CW_ALU_SUB = 11;
    localparam int CW_OUT_IN  = 12;
    localparam int CW_W       = 13;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/tstate_ring.sv
// T-state ring: state register, next-state logic and halt latch.
//
//  state   | meaning
//  --------+---------------------------------------------------
//  IDLE    | waiting for run
//  T1..T3  | fetch: PC->MAR, PC++, RAM->IR
//  T4..T6  | execute, opcode dependent
//  HALT    | HLT executed, held until reset
module tstate_ring
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_i,
    input  logic [3:0] ir_opcode_i,
    output state_e     state_o,
    output logic       halted_o
);

    state_e state_q;
    logic   halted_q;

    // Advance one T-state per clock; HLT diverts to the absorbing HALT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_q <= run_i ? ST_T1 : ST_IDLE;
                ST_T1:   state_q <= ST_T2;
                ST_T2:   state_q <= ST_T3;
                ST_T3:   state_q <= ST_T4;
                ST_T4: begin
                    if (ir_opcode_i == OP_HLT) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= ST_T5;
                    end
                end
                ST_T5:   state_q <= ST_T6;
                ST_T6:   state_q <= run_i ? ST_T1 : ST_IDLE;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state_o  = state_q;
    assign halted_o = halted_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: decodes the T-state and opcode into the
// per-cycle control strobes and counts retired instructions.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       ir_opcode,
    input  logic             zero_flag,
    output logic             pc_in,
    output logic             pc_out,
    output logic             pc_inc,
    output logic             mar_in,
    output logic             ram_out,
    output logic             ir_in,
    output logic             ir_out,
    output logic             a_in,
    output logic             a_out,
    output logic             b_in,
    output logic             alu_out,
    output logic             alu_sub,
    output logic             out_in,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state;
    ctrl_word_t       cw;
    logic [CNT_W-1:0] count_q;

    tstate_ring u_ring (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (run),
        .ir_opcode_i (ir_opcode),
        .state_o     (state),
        .halted_o    (halted)
    );

    // Strobe decode; a single bus driver is selected per T-state/opcode pair.
    always_comb begin
        cw = '0;
        case (state)
            ST_T1: begin
                cw[CW_PC_OUT] = 1'b1;
                cw[CW_MAR_IN] = 1'b1;
            end
            ST_T2: cw[CW_PC_INC] = 1'b1;
            ST_T3: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_IN]   = 1'b1;
            end
            ST_T4: begin
                case (ir_opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_MAR_IN] = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_PC_IN]  = 1'b1;
                    end
                    OP_JZ: begin
                        cw[CW_IR_OUT] = zero_flag;
                        cw[CW_PC_IN]  = zero_flag;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]  = 1'b1;
                        cw[CW_OUT_IN] = 1'b1;
                    end
                    default: cw = '0;
                endcase
            end
            ST_T5: begin
                case (ir_opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_IN]    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_IN]    = 1'b1;
                    end
                    default: cw = '0;
                endcase
            end
            ST_T6: begin
                if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
                    cw[CW_ALU_OUT] = 1'b1;
                    cw[CW_A_IN]    = 1'b1;
                    cw[CW_ALU_SUB] = (ir_opcode == OP_SUB);
                end
            end
            default: cw = '0;
        endcase
    end

    // Retire count bumps on every T6 exit, whichever state follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (state == ST_T6) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign pc_in       = cw[CW_PC_IN];
    assign pc_out      = cw[CW_PC_OUT];
    assign pc_inc      = cw[CW_PC_INC];
    assign mar_in      = cw[CW_MAR_IN];
    assign ram_out     = cw[CW_RAM_OUT];
    assign ir_in       = cw[CW_IR_IN];
    assign ir_out      = cw[CW_IR_OUT];
    assign a_in        = cw[CW_A_IN];
    assign a_out       = cw[CW_A_OUT];
    assign b_in        = cw[CW_B_IN];
    assign alu_out     = cw[CW_ALU_OUT];
    assign alu_sub     = cw[CW_ALU_SUB];
    assign out_in      = cw[CW_OUT_IN];
    assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expectations are queued
// as stimulus advances and compared on the following falling edge.
module tb_control_sequencer;
    import cpu_pkg::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic [3:0]       ir_opcode;
    logic             zero_flag;
    logic             pc_in, pc_out, pc_inc, mar_in, ram_out, ir_in, ir_out;
    logic             a_in, a_out, b_in, alu_out, alu_sub, out_in, halted;
    logic [CNT_W-1:0] instr_count;

    control_sequencer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .ir_opcode   (ir_opcode),
        .zero_flag   (zero_flag),
        .pc_in       (pc_in),
        .pc_out      (pc_out),
        .pc_inc      (pc_inc),
        .mar_in      (mar_in),
        .ram_out     (ram_out),
        .ir_in       (ir_in),
        .ir_out      (ir_out),
        .a_in        (a_in),
        .a_out       (a_out),
        .b_in        (b_in),
        .alu_out     (alu_out),
        .alu_sub     (alu_sub),
        .out_in      (out_in),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        ctrl_word_t       cw;
        logic             hlt;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    exp_t             exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] cnt_m;
    ctrl_word_t       cw_act;
    exp_t             e;

    always_comb begin
        cw_act             = '0;
        cw_act[CW_PC_IN]   = pc_in;
        cw_act[CW_PC_OUT]  = pc_out;
        cw_act[CW_PC_INC]  = pc_inc;
        cw_act[CW_MAR_IN]  = mar_in;
        cw_act[CW_RAM_OUT] = ram_out;
        cw_act[CW_IR_IN]   = ir_in;
        cw_act[CW_IR_OUT]  = ir_out;
        cw_act[CW_A_IN]    = a_in;
        cw_act[CW_A_OUT]   = a_out;
        cw_act[CW_B_IN]    = b_in;
        cw_act[CW_ALU_OUT] = alu_out;
        cw_act[CW_ALU_SUB] = alu_sub;
        cw_act[CW_OUT_IN]  = out_in;
    end

    task automatic check_val(string tag, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val({e.tag, " strobes"}, 32'(cw_act), 32'(e.cw));
            check_val({e.tag, " halted"}, 32'(halted), 32'(e.hlt));
            check_val({e.tag, " count"}, 32'(instr_count), 32'(e.cnt));
        end
    end

    // Expected strobes for T-state t of an instruction, straight from the opcode table.
    function automatic ctrl_word_t exp_word(int t, logic [3:0] op, logic zf);
        ctrl_word_t w;
        w = '0;
        case (t)
            1: begin w[CW_PC_OUT] = 1'b1; w[CW_MAR_IN] = 1'b1; end
            2: w[CW_PC_INC] = 1'b1;
            3: begin w[CW_RAM_OUT] = 1'b1; w[CW_IR_IN] = 1'b1; end
            4: begin
                if (op == OP_LDA || op == OP_ADD || op == OP_SUB) begin
                    w[CW_IR_OUT] = 1'b1; w[CW_MAR_IN] = 1'b1;
                end else if (op == OP_JMP || (op == OP_JZ && zf)) begin
                    w[CW_IR_OUT] = 1'b1; w[CW_PC_IN] = 1'b1;
                end else if (op == OP_OUT) begin
                    w[CW_A_OUT] = 1'b1; w[CW_OUT_IN] = 1'b1;
                end
            end
            5: begin
                if (op == OP_LDA) begin
                    w[CW_RAM_OUT] = 1'b1; w[CW_A_IN] = 1'b1;
                end else if (op == OP_ADD || op == OP_SUB) begin
                    w[CW_RAM_OUT] = 1'b1; w[CW_B_IN] = 1'b1;
                end
            end
            6: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    w[CW_ALU_OUT] = 1'b1; w[CW_A_IN] = 1'b1;
                end
                if (op == OP_SUB) w[CW_ALU_SUB] = 1'b1;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    task automatic tick(ctrl_word_t cw, logic h, string tag);
        exp_t x;
        @(posedge clk);
        #1;
        x.cw  = cw;
        x.hlt = h;
        x.cnt = cnt_m;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    // Opcode is presented during T3 so the previous instruction's T6 decode is undisturbed.
    task automatic run_instr(logic [3:0] op, logic zf, logic drop_run, string tag);
        for (int t = 1; t <= 6; t++) begin
            tick(exp_word(t, op, zf), 1'b0, $sformatf("%s T%0d", tag, t));
            if (t == 3) begin
                ir_opcode = op;
                zero_flag = zf;
                if (drop_run) run = 1'b0;
            end
        end
        cnt_m = cnt_m + 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, queue depth %0d expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        run       = 1'b0;
        ir_opcode = 4'h0;
        zero_flag = 1'b0;
        cnt_m     = '0;
        #2;
        check_val("reset strobes", 32'(cw_act), 32'd0);
        check_val("reset halted", 32'(halted), 32'd0);
        check_val("reset count", 32'(instr_count), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick('0, 1'b0, "idle");

        run = 1'b1;
        run_instr(OP_LDA, 1'b0, 1'b0, "lda");
        run_instr(OP_ADD, 1'b1, 1'b0, "add");
        run_instr(OP_SUB, 1'b0, 1'b0, "sub");
        run_instr(OP_JZ,  1'b1, 1'b0, "jz_taken");
        run_instr(OP_JZ,  1'b0, 1'b0, "jz_not");
        run_instr(OP_JMP, 1'b0, 1'b0, "jmp");
        run_instr(OP_OUT, 1'b1, 1'b0, "out");
        run_instr(4'h7,   1'b1, 1'b0, "nop7");
        run_instr(OP_LDA, 1'b1, 1'b1, "lda_drop");
        repeat (3) tick('0, 1'b0, "idle_after_drop");

        run = 1'b1;
        for (int i = 0; i < 256; i++) begin
            run_instr(4'($urandom_range(5, 13)), 1'($urandom_range(0, 1)),
                      (i == 255), "nop_wrap");
        end
        repeat (2) tick('0, 1'b0, "idle_after_wrap");

        run = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick(exp_word(t, OP_HLT, 1'b0), 1'b0, $sformatf("hlt T%0d", t));
            if (t == 3) ir_opcode = OP_HLT;
        end
        repeat (20) tick('0, 1'b1, "halt");

        @(negedge clk);
        #1;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check_val("halt_reset strobes", 32'(cw_act), 32'd0);
        check_val("halt_reset halted", 32'(halted), 32'd0);
        check_val("halt_reset count", 32'(instr_count), 32'd0);
        cnt_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick('0, 1'b0, "idle_after_halt");

        run       = 1'b1;
        ir_opcode = OP_ADD;
        tick(exp_word(1, OP_ADD, 1'b0), 1'b0, "midrst T1");
        tick(exp_word(2, OP_ADD, 1'b0), 1'b0, "midrst T2");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check_val("midrst strobes", 32'(cw_act), 32'd0);
        check_val("midrst halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick('0, 1'b0, "idle_after_midrst");

        @(negedge clk);
        #1;
        check_val("queue drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
